systolic_skew_feeder: RTL and testbench

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

---
 rtl/systolic_pkg.sv | 11 +
 rtl/skew_delay_line.sv | 24 ++
 rtl/systolic_skew_feeder.sv | 73 +++++++
 tb/tb_systolic_skew_feeder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array edge feeders.
package systolic_pkg;
  localparam int DEF_UWIDTH = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } feeder_state_t;
endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register for one feeder lane; bubbles shift in zeros.
module skew_delay_line #(
  parameter int UWIDTH = 2,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble_i,
  input  logic [UWIDTH-1:0] din_i,
  output logic [UWIDTH-1:0] dout_o
);
  logic [DEPTH-1:0][UWIDTH-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= bubble_i ? '0 : din_i;
      for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign dout_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews operand beats onto a systolic array edge: lane i delayed by i+1 cycles.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int UWIDTH = DEF_UWIDTH,
  parameter int CWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0][UWIDTH-1:0] in_data,
  input  logic                     in_last,
  output logic [N-1:0][UWIDTH-1:0] edge_out,
  output logic                     busy,
  output logic                     done,
  output logic [CWIDTH-1:0]        beat_count
);
  localparam int FW = (N > 2) ? $clog2(N) : 1;
  // FLUSH lasts N-1 cycles, but never less than one.
  localparam logic [FW-1:0] FLUSH_LAST = FW'((N > 1) ? N - 2 : 0);

  feeder_state_t     state_q;
  logic [FW-1:0]     flush_q;
  logic [CWIDTH-1:0] count_q;
  logic              accept;

  assign in_ready   = (state_q == S_IDLE) || (state_q == S_STREAM);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign beat_count = count_q;
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      flush_q <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          count_q <= CWIDTH'(1);
          flush_q <= '0;
          state_q <= in_last ? S_FLUSH : S_STREAM;
        end
        S_STREAM: if (accept) begin
          if (count_q != '1) count_q <= count_q + 1'b1;
          if (in_last) begin
            flush_q <= '0;
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (flush_q == FLUSH_LAST) state_q <= S_DONE;
          else                       flush_q <= flush_q + 1'b1;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(.UWIDTH(UWIDTH), .DEPTH(i + 1)) u_dl (
      .clk      (clk),
      .reset    (reset),
      .bubble_i (!accept),
      .din_i    (in_data[i]),
      .dout_o   (edge_out[i])
    );
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level model.
module tb_systolic_skew_feeder;
  localparam int N  = 4;
  localparam int UW = 2;
  localparam int FLUSH_CYC = (N > 1) ? N - 1 : 1;
  typedef logic [N-1:0][UW-1:0] vec_t;

  logic clk = 0;
  logic reset = 1;
  logic in_valid = 0;
  logic in_last = 0;
  vec_t in_data = '0;
  logic in_ready, busy, done;
  vec_t edge_out;
  logic [7:0] beat_count;
  logic in_ready_2, busy_2, done_2;
  vec_t edge_out_2;
  logic [1:0] beat_count_2;

  int errors = 0;
  int checks = 0;

  // model state: lock = cycles left with in_ready low (FLUSH + DONE)
  int   lock = 0;
  bit   in_stream = 0;
  int   mcnt = 0;
  vec_t hist [N];

  always #5 clk = ~clk;

  systolic_skew_feeder #(.N(N), .UWIDTH(UW), .CWIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .edge_out(edge_out),
    .busy(busy), .done(done), .beat_count(beat_count));

  systolic_skew_feeder #(.N(N), .UWIDTH(UW), .CWIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_2),
    .in_data(in_data), .in_last(in_last), .edge_out(edge_out_2),
    .busy(busy_2), .done(done_2), .beat_count(beat_count_2));

  function automatic vec_t exp_edge();
    vec_t e;
    for (int i = 0; i < N; i++) e[i] = hist[i][i];
    return e;
  endfunction

  function automatic int sat(input int maxv);
    return (mcnt > maxv) ? maxv : mcnt;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = UW'($urandom_range(0, (1 << UW) - 1));
    return v;
  endfunction

  function automatic vec_t rand_nz_vec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = UW'($urandom_range(1, (1 << UW) - 1));
    return v;
  endfunction

  task automatic step(input bit v, input vec_t d, input bit l, input bit r);
    bit acc;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; reset = r;
    @(posedge clk);
    acc = v && (lock == 0) && !r;
    if (r) begin
      lock = 0; in_stream = 0; mcnt = 0;
      for (int k = 0; k < N; k++) hist[k] = '0;
    end else begin
      for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = acc ? d : '0;
      if (lock > 0) lock--;
      else if (acc) begin
        mcnt = in_stream ? mcnt + 1 : 1;
        if (l) begin lock = FLUSH_CYC + 1; in_stream = 0; end
        else in_stream = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    checks++; if (edge_out !== '0) begin errors++; $display("FAIL reset_edge got=%h want=0", edge_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (beat_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", beat_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    step(0, '0, 0, 0);
  endtask

  task automatic test_single_beat();
    vec_t d, e;
    int ndone = 0;
    d = '0;
    for (int i = 0; i < N; i++) d[i] = UW'(3 - i);
    step(1, d, 1, 0);
    for (int k = 0; k < 6; k++) begin
      e = '0;
      if (k < N) e[k] = UW'(3 - k);
      checks++; if (edge_out !== e) begin errors++; $display("FAIL single_edge k=%0d got=%h want=%h", k, edge_out, e); end
      if (done === 1'b1) begin
        ndone++;
        checks++; if (k != 3) begin errors++; $display("FAIL single_done_time got=%0d want=3", k); end
      end
      step(0, '0, 0, 0);
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL single_done_count got=%0d want=1", ndone); end
    checks++; if (beat_count !== 8'd1) begin errors++; $display("FAIL single_count got=%0d want=1", beat_count); end
  endtask

  task automatic test_back_to_back();
    int nr = 0;
    step(1, rand_vec(), 0, 0);
    step(1, rand_vec(), 0, 0);
    step(1, rand_vec(), 1, 0);
    checks++; if (beat_count !== 8'd3) begin errors++; $display("FAIL b2b_count got=%0d want=3", beat_count); end
    checks++; if (beat_count_2 !== 2'd3) begin errors++; $display("FAIL b2b_count2 got=%0d want=3", beat_count_2); end
    while (in_ready !== 1'b1 && nr < 10) begin
      nr++;
      step(0, '0, 0, 0);
    end
    checks++; if (nr != FLUSH_CYC + 1) begin errors++; $display("FAIL b2b_notready got=%0d want=%0d", nr, FLUSH_CYC + 1); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_bubble();
    vec_t a, b;
    vec_t obs [N + 3];
    a = rand_nz_vec();
    b = rand_nz_vec();
    step(1, a, 0, 0); obs[0] = edge_out;
    step(0, '0, 0, 0); obs[1] = edge_out;
    step(1, b, 1, 0); obs[2] = edge_out;
    for (int j = 3; j < N + 3; j++) begin
      step(0, '0, 0, 0); obs[j] = edge_out;
    end
    for (int i = 0; i < N; i++) begin
      checks++; if (obs[i][i] !== a[i]) begin errors++; $display("FAIL bubble_a lane=%0d got=%0d want=%0d", i, obs[i][i], a[i]); end
      checks++; if (obs[i+1][i] !== '0) begin errors++; $display("FAIL bubble_zero lane=%0d got=%0d want=0", i, obs[i+1][i]); end
      checks++; if (obs[i+2][i] !== b[i]) begin errors++; $display("FAIL bubble_b lane=%0d got=%0d want=%0d", i, obs[i+2][i], b[i]); end
    end
    for (int j = 0; j < 4; j++) step(0, '0, 0, 0);
  endtask

  task automatic test_reset_flush();
    step(1, rand_nz_vec(), 1, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 1);
    checks++; if (edge_out !== '0) begin errors++; $display("FAIL rstflush_edge got=%h want=0", edge_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstflush_busy got=%b want=0", busy); end
    checks++; if (beat_count !== 8'd0) begin errors++; $display("FAIL rstflush_count got=%0d want=0", beat_count); end
    for (int k = 0; k < N + 2; k++) begin
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstflush_done k=%0d got=%b want=0", k, done); end
      step(0, '0, 0, 0);
    end
  endtask

  task automatic test_saturate();
    for (int k = 1; k <= 5; k++) begin
      step(1, rand_vec(), k == 5, 0);
      checks++; if (beat_count_2 !== 2'(sat(3))) begin errors++; $display("FAIL sat_count2 k=%0d got=%0d want=%0d", k, beat_count_2, sat(3)); end
      checks++; if (beat_count !== 8'(k)) begin errors++; $display("FAIL sat_count k=%0d got=%0d want=%0d", k, beat_count, k); end
    end
    for (int k = 0; k < N + 1; k++) step(0, '0, 0, 0);
  endtask

  task automatic test_flush_hold();
    step(1, rand_nz_vec(), 1, 0);
    for (int k = 0; k < FLUSH_CYC + 1; k++) begin
      step(1, rand_nz_vec(), 0, 0);
      checks++; if (edge_out !== exp_edge()) begin errors++; $display("FAIL hold_edge k=%0d got=%h want=%h", k, edge_out, exp_edge()); end
      checks++; if (beat_count !== 8'd1) begin errors++; $display("FAIL hold_count k=%0d got=%0d want=1", k, beat_count); end
    end
    step(0, '0, 0, 0);
  endtask

  task automatic test_random();
    bit v, l, r;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 9) < 2);
      r = ($urandom_range(0, 49) == 0);
      step(v, rand_vec(), l, r);
      checks++; if (edge_out !== exp_edge()) begin errors++; $display("FAIL rnd_edge c=%0d got=%h want=%h", c, edge_out, exp_edge()); end
      checks++; if (edge_out_2 !== exp_edge()) begin errors++; $display("FAIL rnd_edge2 c=%0d got=%h want=%h", c, edge_out_2, exp_edge()); end
      checks++; if (in_ready !== (lock == 0)) begin errors++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, in_ready, lock == 0); end
      checks++; if (busy !== (in_stream || lock > 0)) begin errors++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy, in_stream || lock > 0); end
      checks++; if (done !== (lock == 1)) begin errors++; $display("FAIL rnd_done c=%0d got=%b want=%b", c, done, lock == 1); end
      checks++; if (beat_count !== 8'(sat(255))) begin errors++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, beat_count, sat(255)); end
      checks++; if (beat_count_2 !== 2'(sat(3))) begin errors++; $display("FAIL rnd_count2 c=%0d got=%0d want=%0d", c, beat_count_2, sat(3)); end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) hist[k] = '0;
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_bubble();
    test_reset_flush();
    test_saturate();
    test_flush_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
